batch_test_sequencer: RTL and testbench
=======================================

// Module: batch_test_sequencer
// PURPOSE
//  Synthesizable self-checking batch runner for a Start/Ack program core.
//  Per batch: resets the core, preloads IN_WORDS input bytes into core data memory,
//  pulses Start, waits for Ack (with timeout), then compares OUT_WORDS result bytes
//  against expected values. Repeats for NUM_BATCHES; reports pass/fail/timeout counts
//  plus the first mismatch. Sits beside TopLevel and owns its data-memory port while busy.
// PARAMETERS
//  DW          8      data word width
//  IN_WORDS    30     input bytes preloaded per batch (core addr 0..IN_WORDS-1)
//  OUT_BASE    30     core address of first result byte
//  OUT_WORDS   30     result bytes checked per batch
//  NUM_BATCHES 137    batches per campaign
//  VEC_AW      12     vector/expected ROM address width
//  DM_AW       8      core data-memory address width
//  TIMEOUT     65535  max RUN cycles before batch is declared hung
//  CW          16     width of all result counters
// PORTS
//  Clk        in  1       clock, rising edge
//  Reset      in  1       asynchronous, active-low
//  Go         in  1       start campaign; sampled only in IDLE/DONE
//  Vec_Addr   out VEC_AW  address to input ROM and expected ROM
//  Vec_In     in  DW      input ROM data, valid 1 cycle after Vec_Addr
//  Exp_In     in  DW      expected ROM data, valid 1 cycle after Vec_Addr
//  Dm_Wr_En   out 1       core data-memory write strobe
//  Dm_Addr    out DM_AW   core data-memory address
//  Dm_Wr_Data out DW      core data-memory write data
//  Dm_Rd_Data in  DW      core data-memory read data, valid 1 cycle after Dm_Addr
//  Dut_Reset  out 1       active-high reset to core
//  Dut_Start  out 1       Start to core
//  Dut_Ack    in  1       core done flag (level)
//  Busy       out 1       campaign in progress
//  Done       out 1       campaign finished; held until next Go
//  Pass_Cnt   out CW      matching result words
//  Fail_Cnt   out CW      mismatching result words
//  Tmo_Cnt    out CW      batches that timed out
//  Err_Valid  out 1       first-mismatch capture is valid
//  Err_Batch  out CW      batch index of first mismatch
//  Err_Addr   out DM_AW   core address of first mismatch
//  Err_Exp    out DW      expected value of first mismatch
//  Err_Got    out DW      received value of first mismatch
// BEHAVIOUR
//  Reset (Reset=0): state IDLE; every output 0; counters, batch index, captures cleared.
//  FSM: IDLE -Go-> DUT_RST -> LOAD -> START -> RUN -> CHECK -> NEXT -> DUT_RST | DONE.
//  Go in IDLE or DONE clears all counters and Err_*, sets batch b=0, enters DUT_RST.
//  Go in any other state is ignored.
//  DUT_RST: 2 cycles. Dut_Reset=1 in the first cycle, 0 in the second.
//  LOAD: IN_WORDS+1 cycles. Cycle k<IN_WORDS drives Vec_Addr=(b*IN_WORDS+k) mod 2^VEC_AW.
//   Cycle k>=1 writes Vec_In to Dm_Addr=k-1 with Dm_Wr_En=1.
//  START: 1 cycle, Dut_Start=1. Dut_Ack is ignored in this cycle.
//  RUN: cycle counter starts at 0. Dut_Ack=1 -> CHECK. If the counter reaches TIMEOUT
//   with no Ack: Tmo_Cnt+1, skip CHECK, go to NEXT.
//  CHECK: OUT_WORDS+1 cycles. Cycle k<OUT_WORDS drives Dm_Addr=OUT_BASE+k and
//   Vec_Addr=(b*OUT_WORDS+k) mod 2^VEC_AW. Cycle k>=1 compares Dm_Rd_Data with Exp_In:
//   - equal: Pass_Cnt+1
//   - unequal: Fail_Cnt+1; if Err_Valid=0, capture Err_* and set Err_Valid=1
//  NEXT: b+1. If b+1==NUM_BATCHES -> DONE, else -> DUT_RST.
//  DONE: Busy=0, Done=1. Busy=1 in every state except IDLE and DONE.
//  Counters saturate at 2^CW-1 and never wrap.
//  Dm_Wr_En is 0 outside LOAD. Dm_Addr, Vec_Addr and Dm_Wr_Data are 0 when unused.
//  Reset asserted mid-campaign: immediate return to IDLE, all outputs 0, no partial results kept.
//  ROM address wrap is intentional: the final partial batch re-reads from address 0.
// TESTING
//  1 NUM_BATCHES=2, model echoes input+1, ROM expected=input+1
//    -> Pass_Cnt=60, Fail_Cnt=0, Tmo_Cnt=0, Done=1, Err_Valid=0.
//  2 Same as 1, expected byte (batch1, word5) corrupted to 8'hFF
//    -> Fail_Cnt=1, Pass_Cnt=59, Err_Batch=1, Err_Addr=35, Err_Exp=8'hFF.
//  3 Model never acks, TIMEOUT=100, NUM_BATCHES=3
//    -> Tmo_Cnt=3, Pass_Cnt=0, Done within 3*(100+IN_WORDS+5) cycles.
//  4 Reset=0 during CHECK of batch 1 -> all outputs 0 next edge;
//    Go reruns from b=0 with results as in test 1.
//  5 VEC_AW=6, IN_WORDS=30, NUM_BATCHES=3 -> batch 2 reads ROM addr 60..63 then 0..25 (wrap).
//  6 Go pulsed in RUN -> ignored; CW=4 with 30 passes -> Pass_Cnt saturates at 15.

Source files
------------

// File: rtl/batch_test_sequencer.sv
// Batch runner for a Start/Ack core: per batch resets the core, preloads inputs, starts it,
// waits for Ack with a timeout, then checks result bytes against an expected ROM and tallies.
module batch_test_sequencer #(
  parameter int DW          = 8,
  parameter int IN_WORDS    = 30,
  parameter int OUT_BASE    = 30,
  parameter int OUT_WORDS   = 30,
  parameter int NUM_BATCHES = 137,
  parameter int VEC_AW      = 12,
  parameter int DM_AW       = 8,
  parameter int TIMEOUT     = 65535,
  parameter int CW          = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Go,
  output logic [VEC_AW-1:0] Vec_Addr,
  input  logic [DW-1:0]     Vec_In,
  input  logic [DW-1:0]     Exp_In,
  output logic              Dm_Wr_En,
  output logic [DM_AW-1:0]  Dm_Addr,
  output logic [DW-1:0]     Dm_Wr_Data,
  input  logic [DW-1:0]     Dm_Rd_Data,
  output logic              Dut_Reset,
  output logic              Dut_Start,
  input  logic              Dut_Ack,
  output logic              Busy,
  output logic              Done,
  output logic [CW-1:0]     Pass_Cnt,
  output logic [CW-1:0]     Fail_Cnt,
  output logic [CW-1:0]     Tmo_Cnt,
  output logic              Err_Valid,
  output logic [CW-1:0]     Err_Batch,
  output logic [DM_AW-1:0]  Err_Addr,
  output logic [DW-1:0]     Err_Exp,
  output logic [DW-1:0]     Err_Got
);

  typedef enum logic [2:0] {
    S_IDLE, S_DUT_RST, S_LOAD, S_START, S_RUN, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [31:0] batch;
  logic        cmp_en;
  logic        run_tmo;
  logic        launch;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    Vec_Addr   = '0;
    Dm_Wr_En   = 1'b0;
    Dm_Addr    = '0;
    Dm_Wr_Data = '0;
    Dut_Reset  = 1'b0;
    Dut_Start  = 1'b0;
    Busy       = 1'b1;
    Done       = 1'b0;
    cmp_en     = 1'b0;
    run_tmo    = 1'b0;
    launch     = 1'b0;
    case (state)
      S_IDLE: begin
        Busy   = 1'b0;
        launch = Go;
        if (Go) state_nxt = S_DUT_RST;
      end
      S_DUT_RST: begin
        Dut_Reset = (cnt == 32'd0);
        if (cnt == 32'd1) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        // ROM data lags its address by one cycle, so write k-1 while addressing k
        if (cnt < IN_WORDS) Vec_Addr = VEC_AW'(batch * IN_WORDS + cnt);
        if (cnt != 32'd0) begin
          Dm_Wr_En   = 1'b1;
          Dm_Addr    = DM_AW'(cnt - 32'd1);
          Dm_Wr_Data = Vec_In;
        end
        if (cnt == IN_WORDS) state_nxt = S_START;
      end
      S_START: begin
        Dut_Start = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (Dut_Ack) begin
          state_nxt = S_CHECK;
        end else if (cnt == TIMEOUT - 1) begin
          run_tmo   = 1'b1;
          state_nxt = S_NEXT;
        end
      end
      S_CHECK: begin
        if (cnt < OUT_WORDS) begin
          Dm_Addr  = DM_AW'(OUT_BASE + cnt);
          Vec_Addr = VEC_AW'(batch * OUT_WORDS + cnt);
        end
        cmp_en = (cnt != 32'd0);
        if (cnt == OUT_WORDS) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (batch + 32'd1 == NUM_BATCHES) state_nxt = S_DONE;
        else                              state_nxt = S_DUT_RST;
      end
      S_DONE: begin
        Busy   = 1'b0;
        Done   = 1'b1;
        launch = Go;
        if (Go) state_nxt = S_DUT_RST;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt       <= '0;
      batch     <= '0;
      Pass_Cnt  <= '0;
      Fail_Cnt  <= '0;
      Tmo_Cnt   <= '0;
      Err_Valid <= 1'b0;
      Err_Batch <= '0;
      Err_Addr  <= '0;
      Err_Exp   <= '0;
      Err_Got   <= '0;
    end else begin
      if (state_nxt != state || state == S_IDLE || state == S_DONE) cnt <= '0;
      else                                                          cnt <= cnt + 32'd1;

      if (launch) begin
        batch     <= '0;
        Pass_Cnt  <= '0;
        Fail_Cnt  <= '0;
        Tmo_Cnt   <= '0;
        Err_Valid <= 1'b0;
        Err_Batch <= '0;
        Err_Addr  <= '0;
        Err_Exp   <= '0;
        Err_Got   <= '0;
      end

      if (state == S_NEXT) batch <= batch + 32'd1;

      if (run_tmo && !(&Tmo_Cnt)) Tmo_Cnt <= Tmo_Cnt + CW'(1);

      if (cmp_en) begin
        if (Dm_Rd_Data == Exp_In) begin
          if (!(&Pass_Cnt)) Pass_Cnt <= Pass_Cnt + CW'(1);
        end else begin
          if (!(&Fail_Cnt)) Fail_Cnt <= Fail_Cnt + CW'(1);
          if (!Err_Valid) begin
            Err_Valid <= 1'b1;
            Err_Batch <= CW'(batch);
            Err_Addr  <= DM_AW'(OUT_BASE + cnt - 32'd1);
            Err_Exp   <= Exp_In;
            Err_Got   <= Dm_Rd_Data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_batch_test_sequencer.sv
// Bench for batch_test_sequencer: two instances (2-batch default-ish, and a 3-batch one with
// 6-bit ROM address and 4-bit counters), each driving a behavioural core and ROM pair.
module tb_batch_test_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go_a = 1'b0;
  logic go_b = 1'b0;
  bit   ack_en_a = 1'b0;
  bit   ack_en_b = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Instance A
  logic [11:0] vaddr_a;
  logic [7:0]  vin_a, ein_a, dm_addr_a, dm_wd_a, dm_rd_a, err_addr_a, err_exp_a, err_got_a;
  logic        dm_we_a, dut_rst_a, dut_start_a, busy_a, done_a, err_vld_a;
  logic        ack_a = 1'b0;
  logic [15:0] pass_a, fail_a, tmo_a, err_batch_a;
  logic [7:0]  vec_a [4096];
  logic [7:0]  exp_a [4096];
  logic [7:0]  mem_a [256];
  int          dly_a = 0;

  batch_test_sequencer #(.NUM_BATCHES(2), .TIMEOUT(100)) u_a (
    .Clk(clk), .Reset(rst_n), .Go(go_a), .Vec_Addr(vaddr_a), .Vec_In(vin_a), .Exp_In(ein_a),
    .Dm_Wr_En(dm_we_a), .Dm_Addr(dm_addr_a), .Dm_Wr_Data(dm_wd_a), .Dm_Rd_Data(dm_rd_a),
    .Dut_Reset(dut_rst_a), .Dut_Start(dut_start_a), .Dut_Ack(ack_a), .Busy(busy_a), .Done(done_a),
    .Pass_Cnt(pass_a), .Fail_Cnt(fail_a), .Tmo_Cnt(tmo_a), .Err_Valid(err_vld_a),
    .Err_Batch(err_batch_a), .Err_Addr(err_addr_a), .Err_Exp(err_exp_a), .Err_Got(err_got_a)
  );

  // Core model: a few cycles after Start, writes input+1 to the result area and raises Ack
  always @(posedge clk) begin
    dm_rd_a <= mem_a[dm_addr_a];
    vin_a   <= vec_a[vaddr_a];
    ein_a   <= exp_a[vaddr_a];
    if (dm_we_a) mem_a[dm_addr_a] <= dm_wd_a;
    if (dut_rst_a) begin
      ack_a <= 1'b0;
      dly_a <= 0;
    end else if (dut_start_a && ack_en_a) begin
      dly_a <= 4;
    end else if (dly_a == 1) begin
      for (int i = 0; i < 30; i++) mem_a[30+i] <= mem_a[i] + 8'd1;
      ack_a <= 1'b1;
      dly_a <= 0;
    end else if (dly_a > 1) begin
      dly_a <= dly_a - 1;
    end
  end

  // Instance B
  logic [5:0]  vaddr_b;
  logic [7:0]  vin_b, ein_b, dm_addr_b, dm_wd_b, dm_rd_b, err_addr_b, err_exp_b, err_got_b;
  logic        dm_we_b, dut_rst_b, dut_start_b, busy_b, done_b, err_vld_b;
  logic        ack_b = 1'b0;
  logic [3:0]  pass_b, fail_b, tmo_b, err_batch_b;
  logic [7:0]  vec_b [64];
  logic [7:0]  exp_b [64];
  logic [7:0]  mem_b [256];
  int          dly_b = 0;

  batch_test_sequencer #(.NUM_BATCHES(3), .VEC_AW(6), .TIMEOUT(100), .CW(4)) u_b (
    .Clk(clk), .Reset(rst_n), .Go(go_b), .Vec_Addr(vaddr_b), .Vec_In(vin_b), .Exp_In(ein_b),
    .Dm_Wr_En(dm_we_b), .Dm_Addr(dm_addr_b), .Dm_Wr_Data(dm_wd_b), .Dm_Rd_Data(dm_rd_b),
    .Dut_Reset(dut_rst_b), .Dut_Start(dut_start_b), .Dut_Ack(ack_b), .Busy(busy_b), .Done(done_b),
    .Pass_Cnt(pass_b), .Fail_Cnt(fail_b), .Tmo_Cnt(tmo_b), .Err_Valid(err_vld_b),
    .Err_Batch(err_batch_b), .Err_Addr(err_addr_b), .Err_Exp(err_exp_b), .Err_Got(err_got_b)
  );

  always @(posedge clk) begin
    dm_rd_b <= mem_b[dm_addr_b];
    vin_b   <= vec_b[vaddr_b];
    ein_b   <= exp_b[vaddr_b];
    if (dm_we_b) mem_b[dm_addr_b] <= dm_wd_b;
    if (dut_rst_b) begin
      ack_b <= 1'b0;
      dly_b <= 0;
    end else if (dut_start_b && ack_en_b) begin
      dly_b <= 4;
    end else if (dly_b == 1) begin
      for (int i = 0; i < 30; i++) mem_b[30+i] <= mem_b[i] + 8'd1;
      ack_b <= 1'b1;
      dly_b <= 0;
    end else if (dly_b > 1) begin
      dly_b <= dly_b - 1;
    end
  end

  task automatic pulse_go_a();
    go_a = 1'b1;
    @(posedge clk); #1;
    go_a = 1'b0;
  endtask

  task automatic pulse_go_b();
    go_b = 1'b1;
    @(posedge clk); #1;
    go_b = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, output int n);
    n = 0;
    while (done_a !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    #23;
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0d want 0", busy_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL rst_done got %0d want 0", done_a); end
    n_cmp++; if (pass_a !== 16'd0 || fail_a !== 16'd0 || tmo_a !== 16'd0) begin n_fail++; $display("FAIL rst_cnts got %0d/%0d/%0d want 0/0/0", pass_a, fail_a, tmo_a); end
    n_cmp++; if (vaddr_a !== 12'd0 || dm_addr_a !== 8'd0 || dm_we_a !== 1'b0) begin n_fail++; $display("FAIL rst_bus got va=%0d da=%0d we=%0d want 0", vaddr_a, dm_addr_a, dm_we_a); end
    n_cmp++; if (dut_rst_a !== 1'b0 || dut_start_a !== 1'b0 || err_vld_a !== 1'b0) begin n_fail++; $display("FAIL rst_ctl got r=%0d s=%0d ev=%0d want 0", dut_rst_a, dut_start_a, err_vld_a); end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %0d/%0d want 0/0", busy_a, busy_b); end
  endtask

  task automatic test_basic();
    int n;
    ack_en_a = 1'b1;
    pulse_go_a();
    n_cmp++; if (dut_rst_a !== 1'b1 || busy_a !== 1'b1) begin n_fail++; $display("FAIL dutrst_first got r=%0d b=%0d want 1/1", dut_rst_a, busy_a); end
    @(posedge clk); #1;
    n_cmp++; if (dut_rst_a !== 1'b0) begin n_fail++; $display("FAIL dutrst_second got %0d want 0", dut_rst_a); end
    @(posedge clk); #1;
    n_cmp++; if (dm_we_a !== 1'b0 || vaddr_a !== 12'd0) begin n_fail++; $display("FAIL load0 got we=%0d va=%0d want 0/0", dm_we_a, vaddr_a); end
    @(posedge clk); #1;
    n_cmp++; if (dm_we_a !== 1'b1 || dm_addr_a !== 8'd0 || dm_wd_a !== 8'd3 || vaddr_a !== 12'd1) begin n_fail++; $display("FAIL load1 got we=%0d da=%0d wd=%0d va=%0d want 1/0/3/1", dm_we_a, dm_addr_a, dm_wd_a, vaddr_a); end
    repeat (30) @(posedge clk);
    #1;
    n_cmp++; if (dut_start_a !== 1'b1 || dm_we_a !== 1'b0) begin n_fail++; $display("FAIL start got s=%0d we=%0d want 1/0", dut_start_a, dm_we_a); end
    wait_done_a(2000, n);
    n_cmp++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL basic_done got %0d want 1 (timeout)", done_a); end
    n_cmp++; if (pass_a !== 16'd60) begin n_fail++; $display("FAIL basic_pass got %0d want 60", pass_a); end
    n_cmp++; if (fail_a !== 16'd0 || tmo_a !== 16'd0) begin n_fail++; $display("FAIL basic_fail_tmo got %0d/%0d want 0/0", fail_a, tmo_a); end
    n_cmp++; if (err_vld_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL basic_err_busy got %0d/%0d want 0/0", err_vld_a, busy_a); end
  endtask

  task automatic test_mismatch();
    int n;
    exp_a[35] = 8'hFF;
    pulse_go_a();
    wait_done_a(2000, n);
    n_cmp++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL mm_done got %0d want 1 (timeout)", done_a); end
    n_cmp++; if (pass_a !== 16'd59 || fail_a !== 16'd1) begin n_fail++; $display("FAIL mm_counts got %0d/%0d want 59/1", pass_a, fail_a); end
    n_cmp++; if (err_vld_a !== 1'b1 || err_batch_a !== 16'd1) begin n_fail++; $display("FAIL mm_batch got v=%0d b=%0d want 1/1", err_vld_a, err_batch_a); end
    n_cmp++; if (err_addr_a !== 8'd35) begin n_fail++; $display("FAIL mm_addr got %0d want 35", err_addr_a); end
    n_cmp++; if (err_exp_a !== 8'hFF || err_got_a !== 8'hF9) begin n_fail++; $display("FAIL mm_data got exp=%h got=%h want ff/f9", err_exp_a, err_got_a); end
    exp_a[35] = 8'hF9;
  endtask

  task automatic test_reset_mid();
    int n;
    int hits;
    pulse_go_a();
    hits = 0;
    n = 0;
    while (hits < 2 && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (dm_addr_a == 8'd40 && busy_a) hits++;
    end
    n_cmp++; if (hits !== 2) begin n_fail++; $display("FAIL mid_reach got %0d want 2", hits); end
    n_cmp++; if (pass_a !== 16'd39) begin n_fail++; $display("FAIL mid_pass_before got %0d want 39", pass_a); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 16'd0) begin n_fail++; $display("FAIL mid_rst got b=%0d d=%0d p=%0d want 0", busy_a, done_a, pass_a); end
    n_cmp++; if (dm_addr_a !== 8'd0 || vaddr_a !== 12'd0 || dm_we_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst_bus got da=%0d va=%0d we=%0d want 0", dm_addr_a, vaddr_a, dm_we_a); end
    @(negedge clk) rst_n = 1'b1;
    pulse_go_a();
    wait_done_a(2000, n);
    n_cmp++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL mid_rerun_done got %0d want 1 (timeout)", done_a); end
    n_cmp++; if (pass_a !== 16'd60 || fail_a !== 16'd0 || err_vld_a !== 1'b0) begin n_fail++; $display("FAIL mid_rerun got p=%0d f=%0d ev=%0d want 60/0/0", pass_a, fail_a, err_vld_a); end
  endtask

  task automatic test_timeout_wrap();
    int n;
    ack_en_b = 1'b0;
    pulse_go_b();
    n = 0;
    while (done_b !== 1'b1 && n < 500) begin
      go_b = (n == 60);
      @(posedge clk); #1;
      n++;
    end
    go_b = 1'b0;
    n_cmp++; if (n !== 405) begin n_fail++; $display("FAIL tmo_cycles got %0d want 405", n); end
    n_cmp++; if (tmo_b !== 4'd3) begin n_fail++; $display("FAIL tmo_cnt got %0d want 3", tmo_b); end
    n_cmp++; if (pass_b !== 4'd0 || fail_b !== 4'd0) begin n_fail++; $display("FAIL tmo_pf got %0d/%0d want 0/0", pass_b, fail_b); end
    n_cmp++; if (mem_b[0] !== 8'd181 || mem_b[3] !== 8'd190) begin n_fail++; $display("FAIL wrap_head got %0d/%0d want 181/190", mem_b[0], mem_b[3]); end
    n_cmp++; if (mem_b[4] !== 8'd1 || mem_b[29] !== 8'd76) begin n_fail++; $display("FAIL wrap_tail got %0d/%0d want 1/76", mem_b[4], mem_b[29]); end
  endtask

  task automatic test_saturation();
    int n;
    ack_en_b = 1'b1;
    pulse_go_b();
    n = 0;
    while (done_b !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++; if (done_b !== 1'b1) begin n_fail++; $display("FAIL sat_done got %0d want 1 (timeout)", done_b); end
    n_cmp++; if (pass_b !== 4'd15) begin n_fail++; $display("FAIL sat_pass got %0d want 15", pass_b); end
    n_cmp++; if (fail_b !== 4'd0 || tmo_b !== 4'd0 || err_vld_b !== 1'b0) begin n_fail++; $display("FAIL sat_other got f=%0d t=%0d ev=%0d want 0/0/0", fail_b, tmo_b, err_vld_b); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      vec_a[i] = 8'(i * 7 + 3);
      exp_a[i] = 8'(i * 7 + 4);
    end
    for (int i = 0; i < 64; i++) begin
      vec_b[i] = 8'(i * 3 + 1);
      exp_b[i] = 8'(i * 3 + 2);
    end
    test_reset();
    test_basic();
    test_mismatch();
    test_reset_mid();
    test_timeout_wrap();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
